// File: rtl/iot_riscv_dmem_resp.sv
// iot_riscv_dmem_resp: d_* bus responder in front of a 1-cycle synchronous SRAM.
// Returns read data right-aligned to bit 0 after 1+WAIT_STATES cycles.
module iot_riscv_dmem_resp #(
   parameter int          ADDR_WIDTH  = 14,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h2000_0000
) (
   input  logic                  main_clk_i,
   input  logic                  main_rst_i,
   input  logic                  d_rd_i,
   input  logic                  d_wr_i,
   input  logic [31:0]           d_addr_i,
   input  logic [1:0]            d_size_i,
   input  logic [31:0]           d_wdata_i,
   output logic                  d_grant_o,
   output logic                  d_rdy_o,
   output logic [31:0]           d_rdata_o,
   output logic                  d_err_o,
   output logic                  sram_cs_o,
   output logic                  sram_we_o,
   output logic [3:0]            sram_be_o,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [31:0]           sram_wdata_o,
   input  logic [31:0]           sram_rdata_i
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t      state;
   logic [3:0]  cnt;
   logic        first_r, err_r, isrd_r;
   logic [1:0]  off_r;
   logic [31:0] cap_r, raw;
   logic        acc, err, rdy, bad_region;
   logic [3:0]  be_base;
   assign rdy        = (state == BUSY) && (cnt == 4'd0);
   assign d_grant_o  = ~main_rst_i & ((state == IDLE) | (cnt == 4'd0));
   assign acc        = (d_rd_i | d_wr_i) & d_grant_o;
   assign bad_region = d_addr_i[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2];
   assign err        = (d_rd_i & d_wr_i) | (d_size_i == 2'd3) | ((d_size_i == 2'd1) & d_addr_i[0])
                     | ((d_size_i == 2'd2) & (|d_addr_i[1:0])) | bad_region;
   assign sram_cs_o  = acc & ~err;
   assign sram_we_o  = sram_cs_o & d_wr_i;
   assign sram_addr_o = sram_cs_o ? d_addr_i[ADDR_WIDTH+1:2] : '0;
   always_comb begin
      be_base      = (d_size_i == 2'd0) ? 4'b0001 : (d_size_i == 2'd1) ? 4'b0011 : 4'b1111;
      sram_be_o    = !sram_cs_o ? 4'b0000 : d_wr_i ? be_base << d_addr_i[1:0] : 4'b1111;
      sram_wdata_o = !sram_cs_o ? 32'd0 : (d_size_i == 2'd0) ? {4{d_wdata_i[7:0]}}
                   : (d_size_i == 2'd1) ? {2{d_wdata_i[15:0]}} : d_wdata_i;
   end
   // first cycle after accept takes SRAM data directly; later cycles use the captured copy
   assign raw       = first_r ? sram_rdata_i : cap_r;
   assign d_rdy_o   = rdy;
   assign d_err_o   = rdy & err_r;
   assign d_rdata_o = (rdy & isrd_r & ~err_r) ? raw >> {off_r, 3'b000} : 32'd0;
   always_ff @(posedge main_clk_i or posedge main_rst_i) begin
      if (main_rst_i) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         first_r <= 1'b0;
         cap_r   <= 32'd0;
         off_r   <= 2'd0;
         err_r   <= 1'b0;
         isrd_r  <= 1'b0;
      end else begin
         first_r <= acc;
         if (first_r) cap_r <= sram_rdata_i;
         if (acc) begin
            state  <= BUSY;
            cnt    <= 4'(WAIT_STATES);
            off_r  <= d_addr_i[1:0];
            err_r  <= err;
            isrd_r <= d_rd_i;
         end else if (state == BUSY) begin
            if (cnt != 4'd0) cnt <= cnt - 4'd1;
            else state <= IDLE;
         end
      end
   end
endmodule
